// File: rtl/pcoeff_result_collector.sv
`default_nettype none
// ============================================================================
// pcoeff_result_collector: in-order result FIFO with slowDown backpressure,
// registered valid/ready output, running totals and sticky error flags.  Rev 1.0
// ============================================================================
module pcoeff_result_collector #(
  parameter int DEPTH = 64,
  parameter int SLACK = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     resultValid_i,
  input  logic [47:0]              pcoeffSum_i,
  input  logic [12:0]              pcoeffCount_i,
  input  logic                     eccStatus_i,
  output logic                     slowDown_o,
  output logic                     outValid_o,
  input  logic                     outReady_i,
  output logic [47:0]              outSum_o,
  output logic [12:0]              outCount_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [63:0]              totalSum_o,
  output logic [31:0]              resultsReceived_o,
  output logic                     overflowError_o,
  output logic                     eccErrorSticky_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_LVL   = OW'(DEPTH);
  localparam logic [OW-1:0] SLOW_LVL   = OW'(DEPTH - SLACK);

  logic [60:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] count_q, count_d, count_after_pop;
  logic          outValid_q, slowDown_q, overflow_q, ecc_q;
  logic [60:0]   head_q, head_d;
  logic [63:0]   totalSum_q;
  logic [31:0]   received_q;
  logic          w_push, w_pop, w_drop;

  // outValid_q mirrors (count_q != 0), so a pop is just the handshake.
  assign w_pop  = outValid_q && outReady_i;
  assign w_push = resultValid_i && ((count_q != FULL_LVL) || w_pop);
  assign w_drop = resultValid_i && !w_push;

  always_comb begin
    count_d         = count_q;
    count_after_pop = w_pop ? (count_q - OW'(1)) : count_q;
    rd_ptr_d        = rd_ptr_q + AW'(w_pop);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + OW'(1);
      2'b01:   count_d = count_q - OW'(1);
      default: count_d = count_q;
    endcase
    // A push into an otherwise-empty FIFO has not reached memory yet.
    if (count_after_pop == '0) head_d = {pcoeffSum_i, pcoeffCount_i};
    else                       head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) mem_q[wr_ptr_q] <= {pcoeffSum_i, pcoeffCount_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      outValid_q <= 1'b0;
      head_q     <= '0;
      slowDown_q <= 1'b0;
      totalSum_q <= '0;
      received_q <= '0;
      overflow_q <= 1'b0;
      ecc_q      <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q   <= wr_ptr_q + AW'(1);
        totalSum_q <= totalSum_q + {16'b0, pcoeffSum_i};
        received_q <= received_q + 32'd1;
      end
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      outValid_q <= (count_d != '0);
      if (count_d != '0) head_q <= head_d;
      slowDown_q <= (count_d >= SLOW_LVL);
      overflow_q <= overflow_q | w_drop;
      ecc_q      <= ecc_q | eccStatus_i;
    end
  end

  assign slowDown_o        = slowDown_q;
  assign outValid_o        = outValid_q;
  assign outSum_o          = head_q[60:13];
  assign outCount_o        = head_q[12:0];
  assign occupancy_o       = count_q;
  assign totalSum_o        = totalSum_q;
  assign resultsReceived_o = received_q;
  assign overflowError_o   = overflow_q;
  assign eccErrorSticky_o  = ecc_q;

endmodule
`default_nettype wire

// File: tb/tb_pcoeff_result_collector.sv
`default_nettype none
// ============================================================================
// tb_pcoeff_result_collector: directed + random stimulus, queue scoreboard.
// Rev 1.0
// ============================================================================
module tb_pcoeff_result_collector;

  localparam int DEPTH = 64;
  localparam int SLACK = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rv = 1'b0, ecc = 1'b0, ordy = 1'b0;
  logic [47:0] sum_i = '0;
  logic [12:0] cnt_i = '0;

  logic        slowDown, outValid, overflowError, eccErrorSticky;
  logic [47:0] outSum;
  logic [12:0] outCount;
  logic [6:0]  occupancy;
  logic [63:0] totalSum;
  logic [31:0] resultsReceived;

  pcoeff_result_collector #(.DEPTH(DEPTH), .SLACK(SLACK)) dut (
    .clk(clk), .rst(rst),
    .resultValid_i(rv), .pcoeffSum_i(sum_i), .pcoeffCount_i(cnt_i),
    .eccStatus_i(ecc), .slowDown_o(slowDown), .outValid_o(outValid),
    .outReady_i(ordy), .outSum_o(outSum), .outCount_o(outCount),
    .occupancy_o(occupancy), .totalSum_o(totalSum),
    .resultsReceived_o(resultsReceived), .overflowError_o(overflowError),
    .eccErrorSticky_o(eccErrorSticky)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a plain FIFO of expected results plus running totals.
  logic [60:0] sb [$];
  int          ref_cnt   = 0;
  logic [63:0] ref_total = '0;
  logic [31:0] ref_rcv   = '0;
  bit          ref_ovf   = 1'b0;
  bit          ref_ecc   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advances on each active edge using the inputs held through it.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        sb.delete();
        ref_cnt = 0; ref_total = '0; ref_rcv = '0; ref_ovf = 1'b0; ref_ecc = 1'b0;
      end else begin
        bit pop, acc;
        pop = (ref_cnt > 0) && ordy;
        acc = rv && ((ref_cnt < DEPTH) || pop);
        if (acc) begin
          ref_total = ref_total + 64'(sum_i);
          ref_rcv   = ref_rcv + 32'd1;
        end else if (rv) begin
          ref_ovf = 1'b1;
        end
        ref_cnt = ref_cnt + int'(acc) - int'(pop);
        ref_ecc = ref_ecc | ecc;
      end
    end
  end

  // Scoreboard push: every accepted result enters the expected queue in order.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst && rv && ((sb.size() < DEPTH) || ((sb.size() > 0) && ordy)))
        sb.push_back({sum_i, cnt_i});
    end
  end

  // Monitor on the falling edge: outputs reflect the last edge, ordy is for the next.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("occupancy", 64'(occupancy), 64'(ref_cnt));
      chk("outValid", 64'(outValid), 64'(ref_cnt > 0));
      chk("slowDown", 64'(slowDown), 64'(ref_cnt >= DEPTH - SLACK));
      chk("totalSum", totalSum, ref_total);
      chk("resultsReceived", 64'(resultsReceived), 64'(ref_rcv));
      chk("overflowError", 64'(overflowError), 64'(ref_ovf));
      chk("eccErrorSticky", 64'(eccErrorSticky), 64'(ref_ecc));
      if (ref_cnt > 0) begin
        if (sb.size() == 0) begin
          chk("scoreboard_nonempty", 64'(0), 64'(1));
        end else begin
          chk("head_data", 64'({outSum, outCount}), 64'(sb[0]));
          if (ordy && !rst) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step(input bit v, input logic [47:0] s, input logic [12:0] c,
                      input bit r, input bit e);
    rv = v; sum_i = s; cnt_i = c; ordy = r; ecc = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) step(1'b0, '0, '0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  function automatic logic [47:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[47:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    do_reset(3);
    repeat (2) step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("reset_outSum", 64'(outSum), 64'(0));
    chk("reset_outCount", 64'(outCount), 64'(0));
    chk("reset_occupancy", 64'(occupancy), 64'(0));
    chk("reset_outValid", 64'(outValid), 64'(0));

    // Single result, 1-cycle latency, popped on presentation
    step(1'b1, 48'h0000_0000_1234, 13'd5, 1'b1, 1'b0);
    chk("single_outValid", 64'(outValid), 64'(1));
    chk("single_outSum", 64'(outSum), 64'h1234);
    chk("single_outCount", 64'(outCount), 64'(5));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("single_popped", 64'(outValid), 64'(0));
    chk("single_totalSum", totalSum, 64'h1234);
    chk("single_received", 64'(resultsReceived), 64'(1));

    // Fill to threshold, to full, then overflow
    do_reset(1);
    for (int i = 0; i < 47; i++) step(1'b1, rnd48(), 13'(i), 1'b0, 1'b0);
    chk("slowDown_below", 64'(slowDown), 64'(0));
    step(1'b1, rnd48(), 13'd47, 1'b0, 1'b0);
    chk("slowDown_at48", 64'(slowDown), 64'(1));
    for (int i = 0; i < 16; i++) step(1'b1, rnd48(), 13'(48 + i), 1'b0, 1'b0);
    chk("full_occupancy", 64'(occupancy), 64'(64));
    chk("full_no_ovf", 64'(overflowError), 64'(0));
    step(1'b1, 48'hDEAD, 13'h1FFF, 1'b0, 1'b0);
    chk("ovf_flag", 64'(overflowError), 64'(1));
    chk("ovf_received", 64'(resultsReceived), 64'(64));
    chk("ovf_occupancy", 64'(occupancy), 64'(64));

    // Push+pop at full: no drops
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rnd48(), 13'(100 + i), 1'b1, 1'b0);
      chk("fullpp_occupancy", 64'(occupancy), 64'(64));
    end
    chk("fullpp_received", 64'(resultsReceived), 64'(74));

    // Drain
    for (int k = 1; k <= 64; k++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("drain_slowDown", 64'(slowDown), 64'((64 - k) >= 48));
    end
    chk("drain_empty", 64'(outValid), 64'(0));
    chk("drain_ovf_held", 64'(overflowError), 64'(1));

    // Totals are not truncated to 48 bits
    do_reset(1);
    step(1'b1, 48'hFFFF_FFFF_FFFF, 13'd1, 1'b0, 1'b0);
    step(1'b1, 48'hFFFF_FFFF_FFFF, 13'd2, 1'b0, 1'b0);
    chk("wide_totalSum", totalSum, 64'h1_FFFF_FFFF_FFFE);

    // ECC sticky, then mid-stream reset
    do_reset(1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    repeat (3) step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("ecc_sticky", 64'(eccErrorSticky), 64'(1));
    for (int i = 0; i < 20; i++) step(1'b1, rnd48(), 13'(i), 1'b0, 1'b0);
    chk("mid_occupancy", 64'(occupancy), 64'(20));
    rst = 1'b1;
    step(1'b1, rnd48(), 13'd7, 1'b1, 1'b1);
    rst = 1'b0;
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_outValid", 64'(outValid), 64'(0));
    chk("rst_ecc", 64'(eccErrorSticky), 64'(0));
    chk("rst_total", totalSum, 64'(0));
    chk("rst_received", 64'(resultsReceived), 64'(0));

    // Random traffic with varying consumer speed
    for (int i = 0; i < 4000; i++) begin
      int rprob;
      rprob = ((i / 400) % 3 == 0) ? 15 : (((i / 400) % 3 == 1) ? 55 : 90);
      rst = ($urandom_range(1999) == 0);
      step($urandom_range(99) < 70, rnd48(), 13'($urandom()),
           $urandom_range(99) < rprob, $urandom_range(299) == 0);
    end
    rst = 1'b0;
    repeat (70) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("final_empty", 64'(outValid), 64'(0));

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
